// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and constants for the core's commit trace.
//   trace_kind_e : 2-bit record kind (NONE/RETIRE/STALL/FLUSH)
//   stage_rec_t  : shadow pipeline record {kind, pc, instr}
//   trace_rec_t  : full trace record delivered to the log sink
//   OPC_* / F3_* : opcode and store-width constants
//   store_mask() : trims store data to the width given by funct3
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        KIND_NONE   = 2'd0,
        KIND_RETIRE = 2'd1,
        KIND_STALL  = 2'd2,
        KIND_FLUSH  = 2'd3
    } trace_kind_e;

    typedef struct packed {
        trace_kind_e       kind;
        logic [XLEN-1:0]   pc;
        logic [31:0]       instr;
    } stage_rec_t;

    typedef struct packed {
        trace_kind_e       kind;
        logic [XLEN-1:0]   pc;
        logic [31:0]       instr;
        logic [4:0]        rd_addr;
        logic [XLEN-1:0]   rd_data;
        logic [XLEN-1:0]   mem_addr;
        logic [XLEN-1:0]   mem_data;
    } trace_rec_t;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    function automatic logic [XLEN-1:0] store_mask(input logic [2:0] f3,
                                                   input logic [XLEN-1:0] data);
        case (f3)
            F3_SB:   return {{(XLEN-8){1'b0}}, data[7:0]};
            F3_SH:   return {{(XLEN-16){1'b0}}, data[15:0]};
            F3_SW:   return data;
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: valid/ready FIFO of trace records.
//   clk_i, rst_i (async, active high)
//   push_i/data_i : write side; a push while full (and no pop) is dropped
//   pop_i         : sink ready; pops the head when valid_o is high
//   valid_o/data_o: head entry (all-zero when empty), read from storage only
//   count_o       : occupancy 0..DEPTH
//   overflow_o    : sticky drop flag, cleared only by reset
module trace_fifo import riscv_pkg::*; #(
    parameter int DEPTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  trace_rec_t             data_i,
    input  logic                   pop_i,
    output logic                   valid_o,
    output trace_rec_t             data_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   overflow_o
);
    localparam int AW = $clog2(DEPTH);

    trace_rec_t     mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [AW:0]    count_q, count_d;
    logic           overflow_q;
    logic           empty, full, do_pop, do_push;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i & ~empty;
    // When full, a simultaneous pop frees the head slot, which is exactly
    // the slot the write pointer addresses, so the push can still land.
    assign do_push = push_i & (~full | do_pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) count_d = count_q + 1'b1;
        else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            if (push_i && !do_push) overflow_q <= 1'b1;
        end
    end

    assign valid_o    = ~empty;
    assign data_o     = empty ? '0 : mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/commit_trace_gen.sv
// commit_trace_gen: per-cycle commit trace producer for the 5-stage core.
// Shadows D/E/M/W with {kind, pc, instr} records following the core's
// stall/flush controls, builds a trace record in W and buffers it in a FIFO.
//   fetch side : pc_f_i, instr_f_i, stall_i, flush_d_i, flush_e_i
//   mem side   : mem_addr_m_i, mem_wdata_m_i (sampled on the M->W transfer)
//   writeback  : reg_write_w_i, rd_addr_w_i, rd_data_w_i
//   sink       : trace_valid_o, trace_ready_i, trace_o, count_o, overflow_o
// Build option: define COMMIT_TRACE_BUBBLES_EN to also push STALL/FLUSH
// bubble records; by default only RETIRE records enter the FIFO.
module commit_trace_gen #(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int DEPTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [XLEN-1:0]        pc_f_i,
    input  logic [31:0]            instr_f_i,
    input  logic                   stall_i,
    input  logic                   flush_d_i,
    input  logic                   flush_e_i,
    input  logic [XLEN-1:0]        mem_addr_m_i,
    input  logic [XLEN-1:0]        mem_wdata_m_i,
    input  logic                   reg_write_w_i,
    input  logic [4:0]             rd_addr_w_i,
    input  logic [XLEN-1:0]        rd_data_w_i,
    output logic                   trace_valid_o,
    input  logic                   trace_ready_i,
    output riscv_pkg::trace_rec_t  trace_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   overflow_o
);
    import riscv_pkg::*;

    stage_rec_t      d_q, d_d, e_q, e_d, m_q, w_q;
    logic [XLEN-1:0] w_mem_addr_q, w_mem_addr_d;
    logic [XLEN-1:0] w_mem_data_q, w_mem_data_d;
    trace_rec_t      w_rec;
    logic            w_push;

    always_comb begin
        // Decode: flush beats stall.
        d_d = d_q;
        if (flush_d_i) begin
            d_d.kind  = KIND_FLUSH;
            d_d.pc    = '0;
            d_d.instr = '0;
        end else if (!stall_i) begin
            d_d.kind  = KIND_RETIRE;
            d_d.pc    = pc_f_i;
            d_d.instr = instr_f_i;
        end

        // Execute: a flush with stall is the load-use bubble, otherwise a
        // control-flow flush.
        e_d = d_q;
        if (flush_e_i) begin
            e_d.kind  = stall_i ? KIND_STALL : KIND_FLUSH;
            e_d.pc    = '0;
            e_d.instr = '0;
        end
    end

    // Memory fields are only meaningful for retiring loads/stores.
    always_comb begin
        w_mem_addr_d = '0;
        w_mem_data_d = '0;
        if (m_q.kind == KIND_RETIRE) begin
            if (m_q.instr[6:0] == OPC_LOAD) begin
                w_mem_addr_d = mem_addr_m_i;
                w_mem_data_d = mem_wdata_m_i;
            end else if (m_q.instr[6:0] == OPC_STORE) begin
                w_mem_addr_d = mem_addr_m_i;
                w_mem_data_d = store_mask(m_q.instr[14:12], mem_wdata_m_i);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            d_q          <= '{kind: KIND_NONE, pc: '0, instr: '0};
            e_q          <= '{kind: KIND_NONE, pc: '0, instr: '0};
            m_q          <= '{kind: KIND_NONE, pc: '0, instr: '0};
            w_q          <= '{kind: KIND_NONE, pc: '0, instr: '0};
            w_mem_addr_q <= '0;
            w_mem_data_q <= '0;
        end else begin
            d_q          <= d_d;
            e_q          <= e_d;
            m_q          <= e_q;
            w_q          <= m_q;
            w_mem_addr_q <= w_mem_addr_d;
            w_mem_data_q <= w_mem_data_d;
        end
    end

    always_comb begin
        w_rec          = '0;
        w_rec.kind     = w_q.kind;
        w_rec.pc       = w_q.pc;
        w_rec.instr    = w_q.instr;
        w_rec.mem_addr = w_mem_addr_q;
        w_rec.mem_data = w_mem_data_q;
        // Bubbles never report a register write; x0 never reports data.
        if (w_q.kind == KIND_RETIRE && reg_write_w_i && rd_addr_w_i != 5'd0) begin
            w_rec.rd_addr = rd_addr_w_i;
            w_rec.rd_data = rd_data_w_i;
        end
    end

`ifdef COMMIT_TRACE_BUBBLES_EN
    assign w_push = (w_q.kind != KIND_NONE);
`else
    assign w_push = (w_q.kind == KIND_RETIRE);
`endif

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (w_push),
        .data_i     (w_rec),
        .pop_i      (trace_ready_i),
        .valid_o    (trace_valid_o),
        .data_o     (trace_o),
        .count_o    (count_o),
        .overflow_o (overflow_o)
    );

endmodule

// File: doc/commit_trace_gen.md
Name: commit_trace_gen

Overview:
- Synthesizable producer of the per-cycle commit trace for the 5-stage RISC-V core.
- Shadows the F/D/E/M/W pipeline with its own (pc, instr) record registers, honouring the core's stall and flush controls.
- At writeback it forms one trace record per cycle for a retired instruction or a stall/flush bubble, then buffers it in a valid/ready FIFO for a log sink (sim monitor, debug port).

Parameters:
- XLEN, riscv_pkg::XLEN (32): datapath width.
- DEPTH, 8: trace FIFO entries; power of two, ≥2.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  asynchronous, active-high reset
- pc_f_i  in  XLEN  PC of instruction in fetch
- instr_f_i  in  32  instruction word in fetch
- stall_i  in  1  core stall: holds F and D
- flush_d_i  in  1  clear decode register
- flush_e_i  in  1  clear execute register
- mem_addr_m_i  in  XLEN  memory-stage effective address
- mem_wdata_m_i  in  XLEN  memory-stage store data
- reg_write_w_i  in  1  writeback enable
- rd_addr_w_i  in  5  writeback destination
- rd_data_w_i  in  XLEN  writeback data
- trace_valid_o  out  1  FIFO head valid
- trace_ready_i  in  1  sink accepts head
- trace_o  out  $bits(trace_rec_t)  head record: kind, pc, instr, rd_addr, rd_data, mem_addr, mem_data
- count_o  out  $clog2(DEPTH)+1  FIFO occupancy
- overflow_o  out  1  sticky: a record was dropped

Behaviour:
- Reset (async, immediate):
  - All shadow stages are set to kind NONE.
  - FIFO empty; trace_valid_o=0, count_o=0, overflow_o=0, trace_o=0.
- Kind encoding: NONE=0, RETIRE=1, STALL=2, FLUSH=3. Only non-NONE records are pushed.
- D register, priority order:
  - flush_d_i: kind FLUSH.
  - else stall_i: hold.
  - else load {RETIRE, pc_f_i, instr_f_i}.
- E register:
  - flush_e_i: bubble, kind STALL if stall_i else FLUSH; pc and instr zeroed.
  - else copy D.
- M←E and W←M shift every cycle; there are no M/W stalls.
- On the M→W transfer, capture mem_addr_m_i/mem_wdata_m_i for opcodes LOAD (0000011) and STORE (0100011); zero for all other opcodes.
- Store data is masked by funct3:
  - SB: [7:0]
  - SH: [15:0]
  - SW: full width
- W record, formed combinationally:
  - rd_addr = reg_write_w_i ? rd_addr_w_i : 0.
  - rd_data = 0 whenever rd_addr==0.
  - Bubbles carry rd_addr=0 and mem fields 0.
- Push: at the clock edge ending the W cycle, if W kind≠NONE.
- Latency: a fetch at cycle t with no stall/flush is in W at t+4 and visible on trace_o at t+5.
- FIFO:
  - trace_valid_o = !empty; trace_o is the head entry, registered storage with no comb path from inputs.
  - Pop when trace_valid_o & trace_ready_i.
  - Push and pop in the same cycle are both legal, including when full (net count unchanged) and when empty-with-push (count 1, no bypass).
  - Full, push, no pop: record dropped, overflow_o←1. overflow_o is cleared only by rst_i.
  - Pointers wrap modulo DEPTH.
- stall_i together with flush_d_i: flush wins for D.
- Reset asserted mid-stream: buffered records are discarded; after release the first push is no earlier than 4 cycles later.

Optional Feature:
- Macro: COMMIT_TRACE_BUBBLES_EN.
- Defined: STALL/FLUSH records are pushed as described above.
- Undefined:
  - Bubble kinds are still tracked in the shadow stages but never pushed; only RETIRE records enter the FIFO.
  - kind is always RETIRE at the output.

Decomposition:
- riscv_pkg additions:
  - trace_kind_e (2-bit enum).
  - trace_rec_t (packed struct above).
  - OPC_LOAD/OPC_STORE constants.
  - F3_SB/F3_SH/F3_SW constants.
- Sub-module trace_fifo: parameterized by DEPTH, data type trace_rec_t. Provides push/pop, count and overflow.
- Stage shadowing stays in commit_trace_gen.

Test Plan:
- Reset: assert rst_i mid-stream with 3 entries buffered → trace_valid_o=0, count_o=0, overflow_o=0 within the same cycle, before any clock edge.
- Retire ALU op: pc 0x0, addi x1,x0,5 (0x00500093), W gives rd 1, data 5 → at t+5 RETIRE{pc 0x0, instr 0x00500093, rd 1, data 0x5, mem 0/0}.
- Store: sw x1,8(x0) (0x00102423), mem_addr_m=0x8, wdata=0xDEADBEEF → rd 0, mem_addr 0x8, mem_data 0xDEADBEEF. Repeat as sb (0x00100423) → mem_data 0xEF.
- Load-use: lw at 0x4, dependent add at 0x8; stall_i=flush_e_i=1 for one cycle → sequence RETIRE 0x4, STALL, RETIRE 0x8, with 0x8 appearing exactly once. Without the macro: RETIRE 0x4, RETIRE 0x8.
- Taken branch at 0xC: flush_d_i=flush_e_i=1 for one cycle → RETIRE 0xC, two FLUSH records, then the target PC.
- Backpressure: trace_ready_i=0 with DEPTH+2 retirements → count_o=8, overflow_o=1. Then ready=1 drains the first 8 in PC order, and overflow_o stays 1.
